// File: rtl/komandara_axi_pkg.sv
// AXI response encodings shared by the Komandara AXI4-Lite master and the BRAM slave.
package komandara_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // EXOKAY is a success; only the two error codes raise the core-side error flag.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/komandara_axi4lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface komandara_axi4lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/komandara_axi4lite_master.sv
// Core req/gnt memory port to AXI4-Lite master bridge, one outstanding transaction.
//
// state      | meaning
// ST_IDLE    | grant follows i_req; capture request payload
// ST_WR      | AW and/or W handshake still pending
// ST_WR_RESP | BREADY high, waiting for BVALID
// ST_RD_ADDR | ARVALID held until ARREADY
// ST_RD_RESP | RREADY high, waiting for RVALID
module komandara_axi4lite_master
  import komandara_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req,
  output logic                        o_gnt,
  input  logic                        i_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [2:0]                  i_prot,
  output logic                        o_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic                        o_err,
  komandara_axi4lite_master_if.master m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_RESP
  } state_e;

  state_e                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [2:0]                  prot_q;
  logic                        awvalid_q, wvalid_q, arvalid_q;
  logic                        aw_done_q, w_done_q;
  logic                        rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;

  logic aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q && m_axi.awready;
  assign w_hs   = wvalid_q && m_axi.wready;
  // A handshake on this edge counts as done so both-at-once moves on immediately.
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            wstrb_q <= i_wstrb;
            prot_q  <= i_prot;
            if (i_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.bvalid) begin
            err_q    <= resp_is_err(m_axi.bresp);
            rvalid_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axi.rvalid) begin
            rdata_q  <= m_axi.rdata;
            err_q    <= resp_is_err(m_axi.rresp);
            rvalid_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt    = (state_q == ST_IDLE) && i_req;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_err    = err_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = prot_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == ST_WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = prot_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == ST_RD_RESP);

endmodule

// File: tb/tb_komandara_axi4lite_master.sv
// Self-checking bench: table of single transactions against a delay-programmable slave,
// plus back-to-back and mid-transaction reset sequences.
module tb_komandara_axi4lite_master;
  import komandara_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [2:0]  prot;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  komandara_axi4lite_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  komandara_axi4lite_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_prot(prot), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_err(err), .m_axi(axi)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    int          aw_dly, w_dly, ar_dly, rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        exp_err;
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  txn_t        vecs[8];
  int          n_vec = 0, n_bad = 0;
  logic [31:0] last_rd = '0;

  // slave configuration and captured bus payload
  int          cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_rsp = 0;
  logic [1:0]  cfg_resp = RESP_OKAY;
  logic [31:0] cfg_rdata = '0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Slave: each READY rises after its VALID has been seen for cfg cycles.
  initial begin
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0;  axi.bresp = RESP_OKAY;
    axi.rvalid = 0;  axi.rresp = RESP_OKAY; axi.rdata = '0;
    forever begin
      @(negedge clk);
      if (axi.awvalid) begin
        axi.awready = (aw_cnt == cfg_aw);
        if (axi.awready) begin cap_awaddr = axi.awaddr; cap_awprot = axi.awprot; end
        aw_cnt++;
      end else begin axi.awready = 0; aw_cnt = 0; end
      if (axi.wvalid) begin
        axi.wready = (w_cnt == cfg_w);
        if (axi.wready) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
        w_cnt++;
      end else begin axi.wready = 0; w_cnt = 0; end
      if (axi.arvalid) begin
        axi.arready = (ar_cnt == cfg_ar);
        if (axi.arready) begin cap_araddr = axi.araddr; cap_arprot = axi.arprot; end
        ar_cnt++;
      end else begin axi.arready = 0; ar_cnt = 0; end
      if (axi.bready) begin
        axi.bvalid = (b_cnt == cfg_rsp); axi.bresp = cfg_resp; b_cnt++;
      end else begin axi.bvalid = 0; b_cnt = 0; end
      if (axi.rready) begin
        axi.rvalid = (r_cnt == cfg_rsp); axi.rresp = cfg_resp; axi.rdata = cfg_rdata; r_cnt++;
      end else begin axi.rvalid = 0; r_cnt = 0; end
    end
  end

  task automatic run_txn(input txn_t v);
    int   mx, lat;
    bit   seen;
    exp_t ex;
    cfg_aw = v.aw_dly; cfg_w = v.w_dly; cfg_ar = v.ar_dly; cfg_rsp = v.rsp_dly;
    cfg_resp = v.resp; cfg_rdata = v.rdata;
    cap_awaddr = '1; cap_wdata = '1; cap_araddr = '1; cap_wstrb = '0;
    cap_awprot = '0; cap_arprot = '0;
    @(negedge clk);
    req = 1; we = v.we; addr = v.addr; wdata = v.wdata; wstrb = v.wstrb; prot = v.prot;
    #1;
    check("gnt", gnt, 1);
    if (!v.we) last_rd = v.rdata;
    exp_q.push_back('{v.exp_err, last_rd});
    mx  = v.we ? ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) : v.ar_dly;
    lat = mx + 3 + v.rsp_dly;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      req = 0;
      if (rvalid) begin
        seen = 1;
        check("latency", k, lat);
        if (exp_q.size() == 0) check("queue_empty", 1, 0);
        else begin
          ex = exp_q.pop_front();
          check("rdata", rdata, ex.rdata);
          check("err", err, ex.err);
        end
      end else begin
        check("awvalid", axi.awvalid, v.we && k <= v.aw_dly + 1);
        check("wvalid", axi.wvalid, v.we && k <= v.w_dly + 1);
        check("arvalid", axi.arvalid, !v.we && k <= v.ar_dly + 1);
        check("bready", axi.bready, v.we && k >= mx + 2);
        check("rready", axi.rready, !v.we && k >= mx + 2);
      end
    end
    if (!seen) check("rvalid_timeout", 0, 1);
    else begin
      @(negedge clk);
      check("rvalid_pulse", rvalid, 0);
    end
    if (v.we) begin
      check("awaddr", cap_awaddr, v.addr);
      check("awprot", cap_awprot, v.prot);
      check("wdata", cap_wdata, v.wdata);
      check("wstrb", cap_wstrb, v.wstrb);
    end else begin
      check("araddr", cap_araddr, v.addr);
      check("arprot", cap_arprot, v.prot);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_valids"}, {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check({tag, "_readys"}, {axi.bready, axi.rready}, 0);
    check({tag, "_awaddr"}, axi.awaddr, 0);
    check({tag, "_wdata"}, axi.wdata, 0);
    check({tag, "_gnt"}, gnt, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n_g, n_rv, last_g;
    exp_t ex;
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 0, RESP_OKAY,   32'h0,        1'b0};
    vecs[1] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 3'd2, 3, 0, 0, 0, RESP_OKAY,   32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h24, 32'h0,        4'h0, 3'd5, 0, 0, 3, 0, RESP_OKAY,   32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 32'h30, 32'h11223344, 4'hC, 3'd1, 0, 2, 0, 1, RESP_OKAY,   32'h0,        1'b0};
    vecs[4] = '{1'b0, 32'h40, 32'h0,        4'h0, 3'd0, 0, 0, 0, 2, RESP_DECERR, 32'hA5A5A5A5, 1'b1};
    vecs[5] = '{1'b1, 32'h50, 32'h0F0F0F0F, 4'h1, 3'd0, 1, 1, 0, 0, RESP_SLVERR, 32'h0,        1'b1};
    vecs[6] = '{1'b1, 32'h54, 32'h01010101, 4'hF, 3'd0, 0, 0, 0, 0, RESP_EXOKAY, 32'h0,        1'b0};
    vecs[7] = '{1'b0, 32'h58, 32'h0,        4'h0, 3'd7, 0, 0, 1, 0, RESP_EXOKAY, 32'h0BADF00D, 1'b0};

    rst = 1; req = 0; we = 0; addr = '0; wdata = '0; wstrb = '0; prot = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // back-to-back: i_req held, alternating read/write, zero-wait slave
    cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_rsp = 0; cfg_resp = RESP_OKAY;
    n_g = 0; n_rv = 0; last_g = 0;
    for (int c = 0; c < 40 && (n_g < 4 || n_rv < 4); c++) begin
      @(negedge clk);
      req = (n_g < 4); we = n_g[0]; addr = 32'h100 + 32'(n_g) * 4;
      wdata = 32'hB0B0_0000 + 32'(n_g); wstrb = 4'hF; prot = 3'd0;
      #1;
      check("single_outstanding", axi.arvalid && (axi.awvalid || axi.wvalid), 0);
      if (rvalid) begin
        n_rv++;
        if (exp_q.size() == 0) check("b2b_queue_empty", 1, 0);
        else begin
          ex = exp_q.pop_front();
          check("b2b_rdata", rdata, ex.rdata);
          check("b2b_err", err, ex.err);
        end
      end
      if (gnt) begin
        if (n_g > 0) check("grant_spacing", c - last_g, 3);
        last_g = c;
        if (!we) begin cfg_rdata = 32'h5A00_0000 + 32'(n_g); last_rd = cfg_rdata; end
        exp_q.push_back('{1'b0, last_rd});
        n_g++;
      end
    end
    req = 0;
    check("b2b_grants", n_g, 4);
    check("b2b_responses", n_rv, 4);

    // reset while AW/W are still pending
    cfg_aw = 20; cfg_w = 20;
    @(negedge clk);
    req = 1; we = 1; addr = 32'h200; wdata = 32'h77778888; wstrb = 4'hF;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    check("pre_reset_awvalid", axi.awvalid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_all_zero("midreset");
    exp_q.delete();
    last_rd = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_no_rvalid", rvalid, 0);
    end
    run_txn('{1'b0, 32'h300, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, RESP_OKAY, 32'hFEEDFACE, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
